blit_scheduler: RTL and testbench
=================================

# blit_scheduler

Controller that shares one fixed-size rectangle blitter between two sprite requesters and feeds the VGA adapter's plot port. For each accepted job it erases the requester's previously drawn rectangle in background colour, then draws the rectangle at the new origin in the requester's colour. It sits between the game-logic FSMs and the VGA adapter, and owns the pixel sweep counters.

## Interface
- SPR_W, 27: rectangle width in pixels.
- SPR_H, 48: rectangle height in pixels.
- BG_COLOUR, 3'b000: erase colour.
- X_INIT, 160 / Y_INIT, 190: origin stored per requester at reset.
- clock  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset. Asynchronous and active-high: 1 = reset asserted.
- req  in  2  job request, one bit per requester; held until granted.
- x0_in, y0_in  in  8 each  requester 0 new origin.
- x1_in, y1_in  in  8 each  requester 1 new origin.
- colour0_in, colour1_in  in  3 each  draw colour per requester.
- grant  out  2  one-hot single-cycle pulse; origin and colour are sampled in this cycle.
- busy  out  1  high from LATCH through DONE.
- done  out  1  one-cycle pulse at job completion.
- plot  out  1  VGA write enable.
- x_out, y_out  out  8 each  pixel coordinate.
- colour_out  out  3  pixel colour.

## Operation
- Reset values:
  - state = IDLE.
  - grant, busy, done, plot, x_out, y_out, colour_out = 0.
  - Stored origins = (X_INIT, Y_INIT).
  - drawn_valid[1:0] = 0.
  - rr_ptr = 0, so requester 0 wins the first tie.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - If exactly one request is asserted, grant it.
  - If both are asserted, grant the requester selected by rr_ptr, then point rr_ptr at the other requester.
  - On a grant, latch the new origin and colour, and go to LATCH.
- LATCH: one cycle. Clear the sweep counters. Go to ERASE if drawn_valid[g], else go to DRAW.
- ERASE: one pixel per cycle at (old_x+ix, old_y+iy) in BG_COLOUR.
  - Raster order: ix runs 0..SPR_W-1 fastest, then iy runs 0..SPR_H-1.
  - After pixel (SPR_W-1, SPR_H-1), go to DRAW with the counters cleared. There is no gap cycle.
- DRAW: same sweep at the new origin in the latched colour. After the last pixel, go to DONE.
- DONE: one cycle.
  - done = 1.
  - The stored origin for g takes the new origin.
  - drawn_valid[g] = 1.
  - Return to IDLE.
- Arithmetic: the coordinate sum is 8-bit and wraps modulo 256. There is no clipping.
- A req bit asserted while busy is ignored until IDLE. A req dropped before its grant is a withdrawn request.
- Reset asserted mid-job: everything returns to reset values at once. The partial job is abandoned and no erase of it ever occurs.

## Timing
All outputs are registered. Let the grant pulse be in cycle g.

**Job with erase:**
- Cycle g+1: LATCH.
- Cycles g+2 .. g+2593: plot high for 2·SPR_W·SPR_H = 2592 consecutive cycles.
  - First pixel: erase of (old_x, old_y).
  - Pixel g+1298: first draw pixel.
- Cycle g+2594: done high, plot low.

**Job without erase:**
- Cycles g+2 .. g+1297: plot high.
- Cycle g+1298: done high.

**Both cases:**
- busy is high from g+1 through the done cycle.
- The earliest next grant is in the cycle after done.
- plot is never high in IDLE, LATCH or DONE.

## Structure
- Shared package blit_pkg holds:
  - state encodings IDLE, LATCH, ERASE, DRAW, DONE;
  - defaults for SPR_W, SPR_H and BG_COLOUR;
  - coordinate width 8 and colour width 3.
- Sub-module rect_sweep contains:
  - ix/iy counters with clear and enable inputs;
  - a `last` output that is high on (SPR_W-1, SPR_H-1).
- The scheduler FSM, arbiter and origin registers live in blit_scheduler.

## Test plan
- First draw, no erase: reset, then req=01 with (10,20) and colour 3'b100.
  - grant=01 for one cycle.
  - 1296 plots covering x 10..36 and y 20..67, all colour 100.
  - done at g+1298.
- Erase then draw: repeat requester 0 with (12,20).
  - 1296 plots at the old rectangle (10,20) in colour 000, then 1296 plots at (12,20).
  - done at g+2594.
- Round-robin: hold req=11 from reset.
  - Grants alternate 01, 10, 01.
  - Each job completes before the next grant.
  - req1 held during a requester-0 job is served next.
- Wrap-around: origin (240,230).
  - x_out sequence wraps 250, 251 … 255, 0 … 10.
  - y_out wraps modulo 256.
  - No clipping.
- Reset mid-ERASE: assert resetn at pixel 500.
  - plot drops to 0 immediately.
  - After release, the next request from either requester draws without erasing.
- req pulse during busy: deassert it before DONE.
  - No grant is issued.
  - The scheduler stays in IDLE.

Source files
------------

// File: rtl/blit_pkg.sv
// Shared types and defaults for the sprite blit scheduler.
package blit_pkg;

    localparam int unsigned COORD_W  = 8;
    localparam int unsigned COLOUR_W = 3;

    localparam int unsigned SPR_W_DEF = 27;
    localparam int unsigned SPR_H_DEF = 48;
    localparam logic [COLOUR_W-1:0] BG_COLOUR_DEF = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        ERASE,
        DRAW,
        DONE
    } state_e;

endpackage

// File: rtl/rect_sweep.sv
// Raster-order pixel counters for one SPR_W x SPR_H rectangle; wraps to (0,0) after the last pixel.
module rect_sweep
    import blit_pkg::*;
#(
    parameter int unsigned SPR_W = SPR_W_DEF,
    parameter int unsigned SPR_H = SPR_H_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               i_clear,
    input  logic               i_enable,
    output logic [COORD_W-1:0] o_ix,
    output logic [COORD_W-1:0] o_iy,
    output logic               o_last
);

    logic [COORD_W-1:0] r_ix;
    logic [COORD_W-1:0] r_iy;
    logic               w_x_end;

    assign w_x_end = (r_ix == COORD_W'(SPR_W - 1));
    assign o_last  = w_x_end && (r_iy == COORD_W'(SPR_H - 1));
    assign o_ix    = r_ix;
    assign o_iy    = r_iy;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if (i_clear) begin
            r_ix <= '0;
            r_iy <= '0;
        end else if (i_enable) begin
            if (o_last) begin
                r_ix <= '0;
                r_iy <= '0;
            end else if (w_x_end) begin
                r_ix <= '0;
                r_iy <= r_iy + 1'b1;
            end else begin
                r_ix <= r_ix + 1'b1;
            end
        end
    end

endmodule

// File: rtl/blit_scheduler.sv
// Shares one rectangle blitter between two requesters: erase the old rectangle, draw the new one.
module blit_scheduler
    import blit_pkg::*;
#(
    parameter int unsigned          SPR_W     = SPR_W_DEF,
    parameter int unsigned          SPR_H     = SPR_H_DEF,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR = BG_COLOUR_DEF,
    parameter logic [COORD_W-1:0]   X_INIT    = 8'd160,
    parameter logic [COORD_W-1:0]   Y_INIT    = 8'd190
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [1:0]          req,
    input  logic [COORD_W-1:0]  x0_in,
    input  logic [COORD_W-1:0]  y0_in,
    input  logic [COORD_W-1:0]  x1_in,
    input  logic [COORD_W-1:0]  y1_in,
    input  logic [COLOUR_W-1:0] colour0_in,
    input  logic [COLOUR_W-1:0] colour1_in,
    output logic [1:0]          grant,
    output logic                busy,
    output logic                done,
    output logic                plot,
    output logic [COORD_W-1:0]  x_out,
    output logic [COORD_W-1:0]  y_out,
    output logic [COLOUR_W-1:0] colour_out
);

    state_e r_state;
    state_e w_state_d;

    logic [1:0]               r_grant;
    logic [1:0]               w_grant_d;
    logic                     r_sel;
    logic                     w_sel_d;
    logic                     r_rr;
    logic                     w_rr_d;
    logic                     w_can_arb;

    logic [1:0][COORD_W-1:0]  r_old_x;
    logic [1:0][COORD_W-1:0]  r_old_y;
    logic [1:0]               r_drawn_valid;
    logic [COORD_W-1:0]       r_new_x;
    logic [COORD_W-1:0]       r_new_y;
    logic [COLOUR_W-1:0]      r_colour;

    logic                     r_busy;
    logic                     r_done;
    logic                     r_plot;
    logic [COORD_W-1:0]       r_x_out;
    logic [COORD_W-1:0]       r_y_out;
    logic [COLOUR_W-1:0]      r_colour_out;
    logic                     r_last_shown;

    logic                     w_sweep;
    logic [COORD_W-1:0]       w_ix;
    logic [COORD_W-1:0]       w_iy;
    logic                     w_last;
    logic [COORD_W-1:0]       w_px;
    logic [COORD_W-1:0]       w_py;
    logic [COLOUR_W-1:0]      w_pc;

    // Counters index the pixel that will be registered onto the outputs at the next edge,
    // so they sit at (0,0) throughout IDLE and LATCH.
    rect_sweep #(
        .SPR_W (SPR_W),
        .SPR_H (SPR_H)
    ) u_sweep (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (r_state == IDLE),
        .i_enable (w_sweep),
        .o_ix     (w_ix),
        .o_iy     (w_iy),
        .o_last   (w_last)
    );

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant_d = 2'b00;
        w_sel_d   = r_sel;
        w_rr_d    = r_rr;
        // Arbitrate in DONE too so a held request is granted in the cycle after done.
        w_can_arb = ((r_state == IDLE) && (r_grant == 2'b00)) || (r_state == DONE);

        if (w_can_arb) begin
            unique case (req)
                2'b01: begin
                    w_grant_d = 2'b01;
                    w_sel_d   = 1'b0;
                end
                2'b10: begin
                    w_grant_d = 2'b10;
                    w_sel_d   = 1'b1;
                end
                2'b11: begin
                    w_grant_d = r_rr ? 2'b10 : 2'b01;
                    w_sel_d   = r_rr;
                    w_rr_d    = ~r_rr;
                end
                default: ;
            endcase
        end

        unique case (r_state)
            IDLE:    if (r_grant != 2'b00) w_state_d = LATCH;
            LATCH:   w_state_d = r_drawn_valid[r_sel] ? ERASE : DRAW;
            ERASE:   if (r_last_shown) w_state_d = DRAW;
            DRAW:    if (r_last_shown) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase

        w_sweep = (w_state_d == ERASE) || (w_state_d == DRAW);
        if (w_state_d == ERASE) begin
            w_px = r_old_x[r_sel] + w_ix;
            w_py = r_old_y[r_sel] + w_iy;
            w_pc = BG_COLOUR;
        end else begin
            w_px = r_new_x + w_ix;
            w_py = r_new_y + w_iy;
            w_pc = r_colour;
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            r_grant       <= 2'b00;
            r_sel         <= 1'b0;
            r_rr          <= 1'b0;
            r_old_x       <= {X_INIT, X_INIT};
            r_old_y       <= {Y_INIT, Y_INIT};
            r_drawn_valid <= 2'b00;
            r_new_x       <= '0;
            r_new_y       <= '0;
            r_colour      <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_plot        <= 1'b0;
            r_x_out       <= '0;
            r_y_out       <= '0;
            r_colour_out  <= '0;
            r_last_shown  <= 1'b0;
        end else begin
            r_grant      <= w_grant_d;
            r_sel        <= w_sel_d;
            r_rr         <= w_rr_d;
            r_busy       <= (w_state_d != IDLE);
            r_done       <= (w_state_d == DONE);
            r_plot       <= w_sweep;
            r_last_shown <= w_sweep & w_last;
            if (w_sweep) begin
                r_x_out      <= w_px;
                r_y_out      <= w_py;
                r_colour_out <= w_pc;
            end
            if ((r_state == IDLE) && (r_grant != 2'b00)) begin
                r_new_x  <= r_sel ? x1_in : x0_in;
                r_new_y  <= r_sel ? y1_in : y0_in;
                r_colour <= r_sel ? colour1_in : colour0_in;
            end
            if (r_state == DONE) begin
                r_old_x[r_sel]       <= r_new_x;
                r_old_y[r_sel]       <= r_new_y;
                r_drawn_valid[r_sel] <= 1'b1;
            end
        end
    end

    assign grant      = r_grant;
    assign busy       = r_busy;
    assign done       = r_done;
    assign plot       = r_plot;
    assign x_out      = r_x_out;
    assign y_out      = r_y_out;
    assign colour_out = r_colour_out;

endmodule

// File: tb/tb_blit_scheduler.sv
// Scenario bench for blit_scheduler: pixel scoreboard plus grant/done timing checks.
module tb_blit_scheduler;

    logic       clock;
    logic       resetn;
    logic [1:0] req;
    logic [7:0] x0_in, y0_in, x1_in, y1_in;
    logic [2:0] colour0_in, colour1_in;
    logic [1:0] grant;
    logic       busy, done, plot;
    logic [7:0] x_out, y_out;
    logic [2:0] colour_out;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] m_x [2];
    logic [7:0] m_y [2];
    bit         m_v [2];

    blit_scheduler dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .x0_in      (x0_in),
        .y0_in      (y0_in),
        .x1_in      (x1_in),
        .y1_in      (y1_in),
        .colour0_in (colour0_in),
        .colour1_in (colour1_in),
        .grant      (grant),
        .busy       (busy),
        .done       (done),
        .plot       (plot),
        .x_out      (x_out),
        .y_out      (y_out),
        .colour_out (colour_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every plotted pixel must match the head of the scoreboard.
    always @(negedge clock) begin
        pix_t e;
        if (!resetn && plot === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%b, required no plot",
                         x_out, y_out, colour_out);
            end else begin
                e = sb.pop_front();
                if ({x_out, y_out, colour_out} !== {e.x, e.y, e.c}) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b",
                             x_out, y_out, colour_out, e.x, e.y, e.c);
                end
            end
        end
    end

    task automatic push_rect(input logic [7:0] ox, input logic [7:0] oy, input logic [2:0] c);
        pix_t p;
        for (int iy = 0; iy < 48; iy++) begin
            for (int ix = 0; ix < 27; ix++) begin
                p.x = 8'(int'(ox) + ix);
                p.y = 8'(int'(oy) + iy);
                p.c = c;
                sb.push_back(p);
            end
        end
    endtask

    // Reference model of one job for requester s, using the inputs being presented now.
    task automatic expect_job(input bit s);
        logic [7:0] nx, ny;
        logic [2:0] nc;
        nx = s ? x1_in : x0_in;
        ny = s ? y1_in : y0_in;
        nc = s ? colour1_in : colour0_in;
        if (m_v[s]) push_rect(m_x[s], m_y[s], 3'b000);
        push_rect(nx, ny, nc);
        m_x[s] = nx;
        m_y[s] = ny;
        m_v[s] = 1'b1;
    endtask

    task automatic do_reset();
        resetn = 1'b1;
        req    = 2'b00;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            m_x[i] = 8'd160;
            m_y[i] = 8'd190;
            m_v[i] = 1'b0;
        end
        repeat (3) @(negedge clock);
        resetn = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        req    = 2'b00;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({grant, busy, done, plot} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant/busy/done/plot=%b, required 00000",
                     {grant, busy, done, plot});
        end
        n_checks++;
        if ({x_out, y_out, colour_out} !== 19'b0) begin
            n_fail++;
            $display("FAIL reset_pixel: got x=%0d y=%0d c=%b, required 0 0 000",
                     x_out, y_out, colour_out);
        end
        do_reset();
        repeat (3) @(negedge clock);
        n_checks++;
        if (grant !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got grant=%b busy=%b, required 00 0", grant, busy);
        end
    endtask

    task automatic test_first_draw();
        int k;
        bit seen;
        x0_in = 8'd10; y0_in = 8'd20; colour0_in = 3'b100; req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = (grant != 2'b00);
        end
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL first_grant: got %b, required 01", grant);
        end
        expect_job(1'b0);
        req = 2'b00;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 1) begin
                n_checks++;
                if (grant !== 2'b00 || busy !== 1'b1 || plot !== 1'b0) begin
                    n_fail++;
                    $display("FAIL first_latch: got grant=%b busy=%b plot=%b, required 00 1 0",
                             grant, busy, plot);
                end
            end
        end while (done !== 1'b1 && k < 3000);
        n_checks++;
        if (k != 1298) begin
            n_fail++;
            $display("FAIL first_done_cycle: got g+%0d, required g+1298", k);
        end
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_done_flags: got plot=%b busy=%b, required 0 1", plot, busy);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL first_pixels_left: got %0d, required 0", sb.size());
        end
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL first_after_done: got done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_erase_draw();
        int k;
        bit seen;
        x0_in = 8'd12; y0_in = 8'd20; colour0_in = 3'b100; req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = (grant != 2'b00);
        end
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL erase_grant: got %b, required 01", grant);
        end
        expect_job(1'b0);
        req = 2'b00;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (done !== 1'b1 && k < 4000);
        n_checks++;
        if (k != 2594) begin
            n_fail++;
            $display("FAIL erase_done_cycle: got g+%0d, required g+2594", k);
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL erase_pixels_left: got %0d, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [3];
        int         exp_len [3];
        int         k;
        int         c;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01;
        exp_len[0] = 1298; exp_len[1] = 1298; exp_len[2] = 2594;
        do_reset();
        x0_in = 8'd50;  y0_in = 8'd60; colour0_in = 3'b001;
        x1_in = 8'd100; y1_in = 8'd10; colour1_in = 3'b010;
        req = 2'b11;
        for (int j = 0; j < 3; j++) begin
            c = 0;
            do begin
                @(negedge clock);
                c++;
            end while (grant === 2'b00 && c < 10);
            if (j > 0) begin
                n_checks++;
                if (c != 1) begin
                    n_fail++;
                    $display("FAIL rr_gap_%0d: grant came %0d cycles after done, required 1", j, c);
                end
            end
            n_checks++;
            if (grant !== exp_g[j]) begin
                n_fail++;
                $display("FAIL rr_grant_%0d: got %b, required %b", j, grant, exp_g[j]);
            end
            expect_job(exp_g[j][1]);
            if (j == 1) x0_in = 8'd52;
            if (j == 2) req = 2'b00;
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (done !== 1'b1 && k < 4000);
            n_checks++;
            if (k != exp_len[j] || sb.size() != 0) begin
                n_fail++;
                $display("FAIL rr_job_%0d: done at g+%0d with %0d pixels left, required g+%0d 0",
                         j, k, sb.size(), exp_len[j]);
            end
        end
    endtask

    task automatic test_wrap();
        int k;
        bit seen;
        do_reset();
        x1_in = 8'd240; y1_in = 8'd230; colour1_in = 3'b111; req = 2'b10;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = (grant != 2'b00);
        end
        n_checks++;
        if (grant !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_grant: got %b, required 10", grant);
        end
        expect_job(1'b1);
        req = 2'b00;
        k = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 18) begin
                n_checks++;
                if (x_out !== 8'd0 || y_out !== 8'd230) begin
                    n_fail++;
                    $display("FAIL wrap_x: got x=%0d y=%0d, required 0 230", x_out, y_out);
                end
            end
            if (k == 704) begin
                n_checks++;
                if (x_out !== 8'd240 || y_out !== 8'd0) begin
                    n_fail++;
                    $display("FAIL wrap_y: got x=%0d y=%0d, required 240 0", x_out, y_out);
                end
            end
        end while (done !== 1'b1 && k < 3000);
        n_checks++;
        if (k != 1298 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL wrap_done: done at g+%0d with %0d left, required g+1298 0", k, sb.size());
        end
    endtask

    task automatic test_reset_mid_erase();
        int  k;
        int  plots;
        bit  seen;
        x1_in = 8'd0; y1_in = 8'd0; colour1_in = 3'b011; req = 2'b10;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = (grant != 2'b00);
        end
        expect_job(1'b1);
        req = 2'b00;
        plots = 0;
        k = 0;
        while (plots < 500 && k < 1000) begin
            @(negedge clock);
            #1;
            k++;
            if (plot === 1'b1) plots++;
        end
        n_checks++;
        if (plots != 500 || colour_out !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_erase_reach: got %0d plots c=%b, required 500 000", plots, colour_out);
        end
        resetn = 1'b1;
        #1;
        n_checks++;
        if (plot !== 1'b0 || busy !== 1'b0 || x_out !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: got plot=%b busy=%b x=%0d, required 0 0 0",
                     plot, busy, x_out);
        end
        do_reset();
        for (int s = 0; s < 2; s++) begin
            x0_in = 8'd30; y0_in = 8'd40; colour0_in = 3'b101;
            x1_in = 8'd70; y1_in = 8'd80; colour1_in = 3'b110;
            req = (s == 0) ? 2'b01 : 2'b10;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clock);
                seen = (grant != 2'b00);
            end
            expect_job(s[0]);
            req = 2'b00;
            k = 0;
            do begin
                @(negedge clock);
                k++;
            end while (done !== 1'b1 && k < 3000);
            n_checks++;
            if (k != 1298 || sb.size() != 0) begin
                n_fail++;
                $display("FAIL post_reset_req%0d: done at g+%0d with %0d left, required g+1298 0",
                         s, k, sb.size());
            end
        end
    endtask

    task automatic test_req_pulse_busy();
        int k;
        int grants;
        bit seen;
        do_reset();
        x0_in = 8'd5; y0_in = 8'd5; colour0_in = 3'b011; req = 2'b01;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            seen = (grant != 2'b00);
        end
        expect_job(1'b0);
        req = 2'b00;
        k = 0;
        grants = 0;
        do begin
            @(negedge clock);
            k++;
            if (k == 100) req = 2'b10;
            if (k == 105) req = 2'b00;
            if (grant !== 2'b00) grants++;
        end while (done !== 1'b1 && k < 3000);
        n_checks++;
        if (k != 1298) begin
            n_fail++;
            $display("FAIL pulse_done_cycle: got g+%0d, required g+1298", k);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (grant !== 2'b00) grants++;
        end
        n_checks++;
        if (grants != 0) begin
            n_fail++;
            $display("FAIL pulse_grant: got %0d grants, required 0", grants);
        end
        n_checks++;
        if (busy !== 1'b0 || plot !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL pulse_idle: got busy=%b plot=%b left=%0d, required 0 0 0",
                     busy, plot, sb.size());
        end
    endtask

    initial begin
        resetn = 1'b1;
        req = 2'b00;
        x0_in = '0; y0_in = '0; x1_in = '0; y1_in = '0;
        colour0_in = '0; colour1_in = '0;
        test_reset();
        test_first_draw();
        test_erase_draw();
        test_round_robin();
        test_wrap();
        test_reset_mid_erase();
        test_req_pulse_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
